bus_grant_arbiter: RTL

Round-robin arbiter that grants ownership of the shared datapath bus to one of 32 requesting sources. It sits directly upstream of the 32-to-5 bus-select encoder. Its registered one-hot `grant` vector drives the encoder input, so at most one bit is ever high and the encoder always sees a legal code or all-zeros. It adds grant hold, explicit release, a one-cycle bus turnaround, and a hold-timeout so no source can monopolise the bus.

---
 rtl/bus_grant_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_grant_arbiter.sv
// ---------------------------------------------------------------------------
// bus_grant_arbiter
//
// Round-robin arbiter granting the shared datapath bus to one of 32 sources.
// The registered one-hot grant feeds the 32-to-5 bus-select encoder, so it
// is never allowed to carry more than one set bit.
//
// A tenure ends on an owner release, on the owner dropping its request, or
// after MAX_HOLD owned cycles. Each tenure is followed by one bus-turnaround
// cycle before the next arbitration.
//
// Ports
//   clock        : system clock, rising edge
//   clear        : asynchronous active-high reset
//   req[31:0]    : level-sensitive request lines, bit i = source i
//   release_in   : one-cycle pulse from the current owner ending its tenure
//   grant[31:0]  : registered one-hot grant (or all-zeros)
//   grant_valid  : registered, high exactly when grant is non-zero
//   timeout_flag : registered one-cycle pulse when MAX_HOLD ends a tenure
//
// Parameter
//   MAX_HOLD     : maximum owned cycles per tenure, 0 disables (0..255)
// ---------------------------------------------------------------------------
module bus_grant_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] req,
    input  logic        release_in,
    output logic [31:0] grant,
    output logic        grant_valid,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  owner_q, owner_d;
    logic [31:0] grant_q, grant_d;
    logic        valid_q, valid_d;
    logic        tflag_q, tflag_d;

    logic        pick_found;
    logic [4:0]  pick_idx;
    logic [4:0]  cand;
    logic        end_rel;
    logic        end_to;

    // First requesting source at or above ptr, wrapping 31 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = 5'd0;
        for (int i = 0; i < 32; i++) begin
            cand = ptr_q + 5'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // A release or dropped request takes precedence over the timeout, so the
    // flag only fires when the hold limit alone ends the tenure.
    assign end_rel = release_in | ~req[owner_q];
    assign end_to  = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        grant_d = grant_q;
        valid_d = valid_q;
        tflag_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = 32'd0;
                valid_d = 1'b0;
                if (pick_found) begin
                    grant_d = 32'd1 << pick_idx;
                    valid_d = 1'b1;
                    owner_d = pick_idx;
                    cnt_d   = 8'd1;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (end_rel || end_to) begin
                    grant_d = 32'd0;
                    valid_d = 1'b0;
                    ptr_d   = owner_q + 5'd1;
                    tflag_d = end_to & ~end_rel;
                    state_d = TURN;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            TURN: begin
                // Bus turnaround: requests are not looked at here.
                grant_d = 32'd0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = 32'd0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
            cnt_q   <= 8'd0;
            owner_q <= 5'd0;
            grant_q <= 32'd0;
            valid_q <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            tflag_q <= tflag_d;
        end
    end

    assign grant        = grant_q;
    assign grant_valid  = valid_q;
    assign timeout_flag = tflag_q;

endmodule
